// File: rtl/io_port_endpoint.sv
// ---------------------------------------------------------------------------
// io_port_endpoint
//
// Bridges a core-side register-style port to a pair of external streams
// through two show-ahead FIFOs:
//   inbound  : external stream (in_*)  -> core read side  (io_read_*, io_rden)
//   outbound : core write side (io_write_*, io_wren) -> external stream (out_*)
//
// Ports
//   clock, reset_n       single rising-edge clock, synchronous active-low reset
//   io_read_EF           inbound word available to the core
//   io_read_data         inbound head word (show-ahead)
//   io_rden              core pops the inbound head
//   io_write_EF          outbound space available to the core
//   io_write_data        core write word
//   io_wren              core pushes io_write_data
//   in_data/valid/ready  external inbound stream
//   out_data/valid/ready external outbound stream
//   in_count, out_count  FIFO occupancies, 0..DEPTH
//   underflow            sticky: io_rden seen while inbound FIFO empty
//   overflow             sticky: io_wren seen while outbound FIFO full
//
// Handshake: a stream word moves on a rising edge where valid and ready are
// both 1 in the cycle before that edge; ready/valid driven by this block
// depend only on registered occupancy, never on the partner's valid/ready.
// The core side uses the EF flags the same way: io_rden/io_wren are acted
// on only when the matching EF flag is 1, otherwise they are ignored and
// raise the sticky error flag.
// ---------------------------------------------------------------------------
module io_port_endpoint #(
    parameter int WORD_WIDTH = 36,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  io_read_EF,
    output logic [WORD_WIDTH-1:0] io_read_data,
    input  logic                  io_rden,
    output logic                  io_write_EF,
    input  logic [WORD_WIDTH-1:0] io_write_data,
    input  logic                  io_wren,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   in_count,
    output logic [ADDR_WIDTH:0]   out_count,
    output logic                  underflow,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ZERO_COUNT = '0;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = (ADDR_WIDTH)'(1);

    // Storage is not reset; only pointers, counts and flags are.
    logic [WORD_WIDTH-1:0] in_mem_q  [DEPTH];
    logic [WORD_WIDTH-1:0] out_mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] in_wr_ptr_q,  in_wr_ptr_d;
    logic [ADDR_WIDTH-1:0] in_rd_ptr_q,  in_rd_ptr_d;
    logic [ADDR_WIDTH:0]   in_count_q,   in_count_d;
    logic [ADDR_WIDTH-1:0] out_wr_ptr_q, out_wr_ptr_d;
    logic [ADDR_WIDTH-1:0] out_rd_ptr_q, out_rd_ptr_d;
    logic [ADDR_WIDTH:0]   out_count_q,  out_count_d;
    logic                  underflow_q,  underflow_d;
    logic                  overflow_q,   overflow_d;

    logic in_push, in_pop, out_push, out_pop;
    logic in_not_full, in_not_empty, out_not_full, out_not_empty;

    // Eligibility comes from pre-edge occupancy only, so a full FIFO rejects
    // a push even if a pop happens on the same edge.
    assign in_not_full   = (in_count_q  != FULL_COUNT);
    assign in_not_empty  = (in_count_q  != ZERO_COUNT);
    assign out_not_full  = (out_count_q != FULL_COUNT);
    assign out_not_empty = (out_count_q != ZERO_COUNT);

    // Flags are held low while reset_n is low so nothing handshakes on a
    // reset edge; the event terms below are gated the same way.
    assign in_ready    = reset_n && in_not_full;
    assign io_read_EF  = reset_n && in_not_empty;
    assign io_write_EF = reset_n && out_not_full;
    assign out_valid   = reset_n && out_not_empty;

    assign in_push  = in_valid && in_ready;
    assign in_pop   = io_rden  && io_read_EF;
    assign out_push = io_wren  && io_write_EF;
    assign out_pop  = out_valid && out_ready;

    assign io_read_data = in_mem_q[in_rd_ptr_q];
    assign out_data     = out_mem_q[out_rd_ptr_q];
    assign in_count     = in_count_q;
    assign out_count    = out_count_q;
    assign underflow    = underflow_q;
    assign overflow     = overflow_q;

    always_comb begin
        in_wr_ptr_d  = in_wr_ptr_q;
        in_rd_ptr_d  = in_rd_ptr_q;
        in_count_d   = in_count_q;
        out_wr_ptr_d = out_wr_ptr_q;
        out_rd_ptr_d = out_rd_ptr_q;
        out_count_d  = out_count_q;
        underflow_d  = underflow_q;
        overflow_d   = overflow_q;

        if (in_push) in_wr_ptr_d = in_wr_ptr_q + PTR_ONE;
        if (in_pop)  in_rd_ptr_d = in_rd_ptr_q + PTR_ONE;
        case ({in_push, in_pop})
            2'b10:   in_count_d = in_count_q + 1'b1;
            2'b01:   in_count_d = in_count_q - 1'b1;
            default: in_count_d = in_count_q;
        endcase

        if (out_push) out_wr_ptr_d = out_wr_ptr_q + PTR_ONE;
        if (out_pop)  out_rd_ptr_d = out_rd_ptr_q + PTR_ONE;
        case ({out_push, out_pop})
            2'b10:   out_count_d = out_count_q + 1'b1;
            2'b01:   out_count_d = out_count_q - 1'b1;
            default: out_count_d = out_count_q;
        endcase

        if (io_rden && !in_not_empty) underflow_d = 1'b1;
        if (io_wren && !out_not_full) overflow_d  = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            in_wr_ptr_q  <= '0;
            in_rd_ptr_q  <= '0;
            in_count_q   <= '0;
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            out_count_q  <= '0;
            underflow_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            in_wr_ptr_q  <= in_wr_ptr_d;
            in_rd_ptr_q  <= in_rd_ptr_d;
            in_count_q   <= in_count_d;
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            out_count_q  <= out_count_d;
            underflow_q  <= underflow_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (in_push)  in_mem_q[in_wr_ptr_q]   <= in_data;
        if (out_push) out_mem_q[out_wr_ptr_q] <= io_write_data;
    end

endmodule

// File: tb/tb_io_port_endpoint.sv
// ---------------------------------------------------------------------------
// tb_io_port_endpoint
//
// Directed checks of io_port_endpoint (DEPTH=4, WORD_WIDTH=36) followed by a
// constrained-random run where the core side obeys the EF flags. Inputs
// change 1 time unit after each rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_io_port_endpoint;

    localparam int W     = 36;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic          io_read_EF;
    logic [W-1:0]  io_read_data;
    logic          io_rden;
    logic          io_write_EF;
    logic [W-1:0]  io_write_data;
    logic          io_wren;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   in_count;
    logic [AW:0]   out_count;
    logic          underflow;
    logic          overflow;

    io_port_endpoint #(
        .WORD_WIDTH (W),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .io_read_EF    (io_read_EF),
        .io_read_data  (io_read_data),
        .io_rden       (io_rden),
        .io_write_EF   (io_write_EF),
        .io_write_data (io_write_data),
        .io_wren       (io_wren),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .in_count      (in_count),
        .out_count     (out_count),
        .underflow     (underflow),
        .overflow      (overflow)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] in_q[$];
    logic [W-1:0] out_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    task automatic push_in(input logic [W-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n       = 1'b0;
        io_rden       = 1'b0;
        io_wren       = 1'b0;
        io_write_data = '0;
        in_data       = '0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;

        step();
        step();
        check("rst_in_ready",    in_ready,    1'b0);
        check("rst_out_valid",   out_valid,   1'b0);
        check("rst_read_EF",     io_read_EF,  1'b0);
        check("rst_write_EF",    io_write_EF, 1'b0);
        check("rst_in_count",    in_count,    0);
        check("rst_out_count",   out_count,   0);
        reset_n = 1'b1;
        #1;
        check("post_rst_write_EF", io_write_EF, 1'b1);
        check("post_rst_in_ready", in_ready,    1'b1);
        check("post_rst_read_EF",  io_read_EF,  1'b0);
        check("post_rst_out_valid",out_valid,   1'b0);
        check("post_rst_underflow",underflow,   1'b0);
        check("post_rst_overflow", overflow,    1'b0);

        // Fill inbound back-to-back, then drain.
        for (int i = 1; i <= 4; i++) begin
            in_data  = W'(i);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("fill_in_ready",  in_ready,     1'b0);
        check("fill_in_count",  in_count,     4);
        check("fill_read_EF",   io_read_EF,   1'b1);
        check("fill_head",      io_read_data, 36'h1);
        io_rden = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k < 3) check("drain_head", io_read_data, 64'(k + 2));
        end
        io_rden = 1'b0;
        check("drain_read_EF",  io_read_EF, 1'b0);
        check("drain_in_count", in_count,   0);
        check("drain_in_ready", in_ready,   1'b1);

        // Pop from empty inbound.
        io_rden = 1'b1;
        step();
        io_rden = 1'b0;
        check("uf_flag",     underflow, 1'b1);
        check("uf_in_count", in_count,  0);
        push_in(36'h55);
        check("uf_next_head",  io_read_data, 36'h55);
        check("uf_next_count", in_count,     1);
        io_rden = 1'b1;
        step();
        io_rden = 1'b0;
        check("uf_drained", in_count,  0);
        check("uf_sticky",  underflow, 1'b1);

        // Simultaneous push and pop at count 2 for 10 cycles.
        in_q.delete();
        push_in(36'h10); in_q.push_back(36'h10);
        push_in(36'h11); in_q.push_back(36'h11);
        check("pp_start_count", in_count, 2);
        for (int k = 0; k < 10; k++) begin
            in_data  = 36'h20 + W'(k);
            in_valid = 1'b1;
            io_rden  = 1'b1;
            check("pp_head", io_read_data, in_q[0]);
            step();
            void'(in_q.pop_front());
            in_q.push_back(36'h20 + W'(k));
            check("pp_count", in_count, 2);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("pp_tail_head", io_read_data, in_q[0]);
            step();
            void'(in_q.pop_front());
        end
        io_rden = 1'b0;
        check("pp_end_count", in_count, 0);

        // Outbound full, write while a pop drains one: write is dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            io_wren       = 1'b1;
            io_write_data = 36'hA0 + W'(i);
            step();
        end
        io_wren = 1'b0;
        check("of_full_count", out_count,   4);
        check("of_write_EF",   io_write_EF, 1'b0);
        check("of_out_valid",  out_valid,   1'b1);
        check("of_head",       out_data,    36'hA0);
        io_wren       = 1'b1;
        io_write_data = 36'hAA;
        out_ready     = 1'b1;
        step();
        io_wren   = 1'b0;
        out_ready = 1'b0;
        check("of_flag",  overflow,  1'b1);
        check("of_count", out_count, 3);
        check("of_head2", out_data,  36'hA1);

        // Reset mid-transfer with pushes offered on the reset edge.
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = 36'h77;
        io_wren  = 1'b1;
        io_write_data = 36'h88;
        #1;
        check("mr_out_valid", out_valid,   1'b0);
        check("mr_write_EF",  io_write_EF, 1'b0);
        check("mr_in_ready",  in_ready,    1'b0);
        check("mr_read_EF",   io_read_EF,  1'b0);
        step();
        check("mr_out_count", out_count, 0);
        check("mr_in_count",  in_count,  0);
        check("mr_overflow",  overflow,  1'b0);
        check("mr_underflow", underflow, 1'b0);
        in_valid = 1'b0;
        io_wren  = 1'b0;
        reset_n  = 1'b1;
        #1;
        check("mr_post_write_EF", io_write_EF, 1'b1);
        check("mr_post_in_ready", in_ready,    1'b1);
        check("mr_post_out_valid",out_valid,   1'b0);

        // Random traffic, core obeys the EF flags.
        in_q.delete();
        out_q.delete();
        for (int c = 0; c < 10000; c++) begin
            logic ip, op;
            in_valid      = 1'($urandom_range(0, 1));
            in_data       = rand_word();
            io_rden       = (in_q.size() != 0) && 1'($urandom_range(0, 1));
            io_wren       = (out_q.size() != DEPTH) && 1'($urandom_range(0, 1));
            io_write_data = rand_word();
            out_ready     = 1'($urandom_range(0, 1));
            #0;
            check("r_in_count",  in_count,    in_q.size());
            check("r_out_count", out_count,   out_q.size());
            check("r_read_EF",   io_read_EF,  in_q.size() != 0);
            check("r_write_EF",  io_write_EF, out_q.size() != DEPTH);
            check("r_in_ready",  in_ready,    in_q.size() != DEPTH);
            check("r_out_valid", out_valid,   out_q.size() != 0);
            if (io_rden) check("r_read_data", io_read_data, in_q[0]);
            op = (out_q.size() != 0) && out_ready;
            if (op) check("r_out_data", out_data, out_q[0]);
            ip = in_valid && (in_q.size() != DEPTH);
            if (io_rden) void'(in_q.pop_front());
            if (op)      void'(out_q.pop_front());
            if (ip)      in_q.push_back(in_data);
            if (io_wren) out_q.push_back(io_write_data);
            step();
        end
        in_valid  = 1'b0;
        io_rden   = 1'b0;
        io_wren   = 1'b0;
        out_ready = 1'b0;
        check("r_underflow", underflow, 1'b0);
        check("r_overflow",  overflow,  1'b0);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_port_endpoint.md
IO_PORT_ENDPOINT -- requirements
Module: io_port_endpoint

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 36, giving the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the entries per FIFO; it is a power of two and at least 2.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 2, equal to log2(DEPTH).
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock. All logic is rising-edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port io_read_EF, output, 1 bit: inbound word available to the core.
REQ-007 The block SHALL have port io_read_data, output, WORD_WIDTH bits: inbound head word.
REQ-008 The block SHALL have port io_rden, input, 1 bit: core pops the inbound head.
REQ-009 The block SHALL have port io_write_EF, output, 1 bit: outbound space available to the core.
REQ-010 The block SHALL have port io_write_data, input, WORD_WIDTH bits: core write word.
REQ-011 The block SHALL have port io_wren, input, 1 bit: core pushes io_write_data.
REQ-012 The block SHALL have port in_data, input, WORD_WIDTH bits: external inbound stream data.
REQ-013 The block SHALL have port in_valid, input, 1 bit: external inbound stream valid.
REQ-014 The block SHALL have port in_ready, output, 1 bit: external inbound stream ready.
REQ-015 The block SHALL have port out_data, output, WORD_WIDTH bits: external outbound stream data.
REQ-016 The block SHALL have port out_valid, output, 1 bit: external outbound stream valid.
REQ-017 The block SHALL have port out_ready, input, 1 bit: external outbound stream ready.
REQ-018 The block SHALL have port in_count, output, ADDR_WIDTH+1 bits: inbound FIFO occupancy.
REQ-019 The block SHALL have port out_count, output, ADDR_WIDTH+1 bits: outbound FIFO occupancy.
REQ-020 The block SHALL have port underflow, output, 1 bit: sticky flag, io_rden seen while inbound FIFO empty.
REQ-021 The block SHALL have port overflow, output, 1 bit: sticky flag, io_wren seen while outbound FIFO full.

Function
REQ-022 The inbound FIFO SHALL push in_data on a cycle where in_valid=1 and in_ready=1, and SHALL pop on a cycle where io_rden=1 and in_count!=0.
REQ-023 The outbound FIFO SHALL push io_write_data on a cycle where io_wren=1 and out_count!=DEPTH, and SHALL pop on a cycle where out_valid=1 and out_ready=1.
REQ-024 Push and pop eligibility SHALL be decided from pre-edge occupancy; a full FIFO SHALL reject a push even when a pop occurs in the same cycle.
REQ-025 A simultaneous accepted push and pop SHALL leave the count unchanged and advance both pointers.
REQ-026 Pointers SHALL be ADDR_WIDTH bits and wrap from DEPTH-1 to 0; counts SHALL range from 0 to DEPTH inclusive.
REQ-027 When reset_n=1, io_read_EF SHALL equal (in_count!=0), io_write_EF SHALL equal (out_count!=DEPTH), in_ready SHALL equal (in_count!=DEPTH), and out_valid SHALL equal (out_count!=0); all four are combinational from registered counts.
REQ-028 io_read_data and out_data SHALL present the FIFO head word (show-ahead, zero latency); their value is don't-care when the FIFO is empty.
REQ-029 A pushed word SHALL be visible at the opposite side on the cycle after the push edge (1-cycle latency into an empty FIFO).
REQ-030 io_rden on an empty inbound FIFO SHALL be ignored and SHALL set underflow; io_wren on a full outbound FIFO SHALL be ignored (word dropped) and SHALL set overflow.
REQ-031 underflow and overflow SHALL remain set until reset.
REQ-032 Words SHALL be delivered in FIFO order with no duplication or loss, except for words dropped under REQ-030.

Reset
REQ-033 On a rising edge with reset_n=0, all pointers and counts SHALL become 0, and underflow and overflow SHALL become 0; FIFO storage is not cleared.
REQ-034 While reset_n=0, in_ready, out_valid, io_read_EF, and io_write_EF SHALL be forced to 0.
REQ-035 After reset, io_write_EF and in_ready SHALL be 1, and io_read_EF and out_valid SHALL be 0.
REQ-036 A reset asserted mid-transfer SHALL discard all queued words, and no push or pop SHALL take effect on that edge.

Verification
REQ-037 The bench SHALL cover: DEPTH=4, push in_data 0x1,0x2,0x3,0x4 back-to-back -> in_ready=0 after the 4th edge, io_read_EF=1, io_read_data=0x1; then 4 io_rden -> 0x2,0x3,0x4 in order, then io_read_EF=0.
REQ-038 The bench SHALL cover: outbound full (out_count=4), io_wren with 0xAA while out_ready=1 -> 0xAA dropped, overflow=1, out_count=3.
REQ-039 The bench SHALL cover: io_rden with in_count=0 -> underflow=1, in_count stays 0, pointers unchanged.
REQ-040 The bench SHALL cover: in_count=2, in_valid=1 and io_rden=1 simultaneously for 10 cycles -> in_count=2 throughout, pointers wrap, order preserved.
REQ-041 The bench SHALL cover: out_count=3 with overflow=1, reset_n=0 for 1 cycle -> out_count=0, overflow=0, out_valid=0 during reset, io_write_EF=1 after reset.
REQ-042 The bench SHALL cover: random in_valid/out_ready/io_rden/io_wren for 10k cycles, with the core obeying the EF flags -> scoreboard matches, underflow=0, overflow=0.
